// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
// Widths, access-size encoding and the byte-lane selector live here.
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = WORD_W / BYTE_W;

    typedef enum logic {
        ACC_WORD = 1'b0,
        ACC_BYTE = 1'b1
    } acc_t;

    function automatic logic [1:0] byte_lane(input logic [WORD_W-1:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// One byte lane of the data memory: WORDS bytes, synchronous write,
// combinational read, asynchronous clear of the whole lane.
module data_mem_lane
    import data_mem_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [BYTE_W-1:0] wdata,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [WORDS];

    // Reset wins over a same-edge write, so a write racing reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/data_mem.sv
// Little-endian data memory for the core's memory stage: word/byte access,
// four byte lanes with per-lane write enables and a zero-extending read mux.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int WORDS  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] out_data,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic              isByte
);

    localparam int IDX_W = $clog2(WORDS);

    acc_t                         acc;
    logic [WORD_W-1:0]            addr_w;
    logic [1:0]                   lane;
    logic [IDX_W-1:0]             index;
    logic [LANES-1:0]             lane_we;
    logic [LANES-1:0][BYTE_W-1:0] lane_wdata;
    logic [LANES-1:0][BYTE_W-1:0] lane_rdata;

    assign acc    = acc_t'(isByte);
    assign addr_w = WORD_W'(data_address);
    assign lane   = byte_lane(addr_w);
    // Upper address bits drop out here, which gives the wrap-around.
    assign index  = addr_w[IDX_W+1:2];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_we[g]    = write_enable && (acc == ACC_WORD || lane == 2'(g));
        assign lane_wdata[g] = (acc == ACC_WORD) ? in_data[g*BYTE_W +: BYTE_W]
                                                 : in_data[BYTE_W-1:0];

        data_mem_lane #(.WORDS(WORDS)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[g]),
            .index (index),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    always_comb begin
        out_data = '0;
        if (read_enable) begin
            if (acc == ACC_WORD) out_data = lane_rdata;
            else                 out_data = {{(WORD_W-BYTE_W){1'b0}}, lane_rdata[lane]};
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: reset, word/byte access,
// enables, read-during-write, wrap-around and mid-operation reset.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] in_data = '0;
    logic [31:0] out_data;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic        isByte = 1'b0;

    int checks = 0;
    int failures = 0;

    data_mem #(.WORDS(256), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_address (data_address),
        .in_data      (in_data),
        .out_data     (out_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .isByte       (isByte)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic b);
        @(negedge clk);
        data_address = a; in_data = d; isByte = b; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic b, output logic [31:0] q);
        data_address = a; isByte = b; read_enable = 1'b1;
        #1 q = out_data;
    endtask

    task automatic test_reset;
        logic [31:0] q;
        logic [31:0] addrs [3];
        addrs = '{32'd0, 32'd4, 32'd1020};
        #2 rst = 1'b1;
        #10 rst = 1'b0;
        foreach (addrs[i]) begin
            do_read(addrs[i], 1'b0, q);
            checks++;
            if (q !== 32'h0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", addrs[i], q, 32'h0);
            end
        end
    endtask

    task automatic test_seq_words;
        logic [31:0] q;
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        for (int k = 0; k <= 8; k++) do_write(32'(k), 32'h11111111 * 32'(k), 1'b0);
        addrs = '{32'd0, 32'd4, 32'd8, 32'd5};
        exps  = '{32'h33333333, 32'h77777777, 32'h88888888, 32'h77777777};
        foreach (addrs[i]) begin
            do_read(addrs[i], 1'b0, q);
            checks++;
            if (q !== exps[i]) begin
                failures++;
                $display("FAIL seq_word addr=%0d got=%h exp=%h", addrs[i], q, exps[i]);
            end
        end
    endtask

    task automatic test_bytes;
        logic [31:0] q;
        logic [31:0] addrs [4];
        logic        bs    [4];
        logic [31:0] exps  [4];
        do_write(32'd16, 32'hAABBCCDD, 1'b0);
        do_write(32'd18, 32'hFFFFFF5A, 1'b1);
        addrs = '{32'd16, 32'd19, 32'd18, 32'd16};
        bs    = '{1'b0, 1'b1, 1'b1, 1'b1};
        exps  = '{32'hAA5ACCDD, 32'h000000AA, 32'h0000005A, 32'h000000DD};
        foreach (addrs[i]) begin
            do_read(addrs[i], bs[i], q);
            checks++;
            if (q !== exps[i]) begin
                failures++;
                $display("FAIL byte_access addr=%0d byte=%0b got=%h exp=%h", addrs[i], bs[i], q, exps[i]);
            end
        end
    endtask

    task automatic test_enables;
        logic [31:0] q;
        @(negedge clk);
        data_address = 32'd16; in_data = 32'hFFFFFFFF; isByte = 1'b0; write_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 do_read(32'd16, 1'b0, q);
        checks++;
        if (q !== 32'hAA5ACCDD) begin
            failures++;
            $display("FAIL write_disabled got=%h exp=%h", q, 32'hAA5ACCDD);
        end
        read_enable = 1'b0;
        #1 checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL read_disabled got=%h exp=%h", out_data, 32'h0);
        end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        data_address = 32'd32; in_data = 32'h12345678; isByte = 1'b0;
        write_enable = 1'b1; read_enable = 1'b1;
        #1 checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL rdw_before got=%h exp=%h", out_data, 32'h0);
        end
        @(posedge clk);
        #1 write_enable = 1'b0;
        checks++;
        if (out_data !== 32'h12345678) begin
            failures++;
            $display("FAIL rdw_after got=%h exp=%h", out_data, 32'h12345678);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] q;
        do_write(32'd1024, 32'hDEADBEEF, 1'b0);
        do_read(32'd0, 1'b0, q);
        checks++;
        if (q !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wrap_word got=%h exp=%h", q, 32'hDEADBEEF);
        end
        do_read(32'd1027, 1'b1, q);
        checks++;
        if (q !== 32'h000000DE) begin
            failures++;
            $display("FAIL wrap_byte got=%h exp=%h", q, 32'h000000DE);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] q;
        logic [31:0] addrs [3];
        do_read(32'd16, 1'b0, q);
        checks++;
        if (q !== 32'hAA5ACCDD) begin
            failures++;
            $display("FAIL pre_reset got=%h exp=%h", q, 32'hAA5ACCDD);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL async_clear got=%h exp=%h", out_data, 32'h0);
        end
        data_address = 32'd16; in_data = 32'hCAFEF00D; isByte = 1'b0; write_enable = 1'b1;
        @(posedge clk);
        #1 write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        addrs = '{32'd16, 32'd0, 32'd32};
        foreach (addrs[i]) begin
            do_read(addrs[i], 1'b0, q);
            checks++;
            if (q !== 32'h0) begin
                failures++;
                $display("FAIL post_reset addr=%0d got=%h exp=%h", addrs[i], q, 32'h0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_seq_words;
        test_bytes;
        test_enables;
        test_read_during_write;
        test_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
Byte-addressable data memory for the pipelined ARM-style core's memory stage; little-endian; holds WORDS 32-bit words.
- Supports 32-bit word and 8-bit byte accesses, selected by isByte.
- Writes are synchronous on clk; reads are combinational so load data is available in the same cycle as the address.
- Asynchronous active-high reset clears the whole array.

Parameters:
- WORDS, 256, number of 32-bit words; power of two ≥ 4.
- ADDR_W, 32, width of data_address.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_address  input  ADDR_W  byte address.
- in_data  input  32  write data; byte mode uses bits [7:0] only.
- out_data  output  32  read data.
- read_enable  input  1  enables out_data.
- write_enable  input  1  commits a write at the rising edge.
- isByte  input  1  1 = byte access, 0 = word access.

Behaviour:
- Storage: WORDS*4 bytes. Byte index = data_address modulo (WORDS*4); upper address bits are ignored, so accesses wrap around.
- Word index = byte index >> 2.
- Reset: while rst=1, every byte is 0 asynchronously and writes are blocked. out_data follows its combinational rule and reads 0.
- Word write (write_enable=1, isByte=0): at rising clk, in_data goes to the word at word index.
  - address[1:0] is ignored (force-aligned).
  - Little-endian: in_data[7:0] goes to the lowest byte.
- Byte write (write_enable=1, isByte=1): at rising clk, in_data[7:0] goes to the byte at byte index; other bytes are unchanged.
- write_enable=0: no state change regardless of other inputs.
- Word read (read_enable=1, isByte=0): out_data = aligned word at word index; combinational, zero-cycle latency.
- Byte read (read_enable=1, isByte=1): out_data = {24'b0, byte at byte index} (zero-extended).
- read_enable=0: out_data = 32'h0.
- Read during a write to the same location: before the edge, out_data shows old contents; immediately after the edge, it shows new contents. No bypass.
- read_enable and write_enable both high is legal; each operates independently per the rules above.
- Reset asserted mid-operation: a write at the same edge as rst assertion is lost; contents are 0 until rst deasserts.
- No X on out_data after reset for any address.

Decomposition:
- Package data_mem_pkg:
  - WORD_W=32, BYTE_W=8.
  - Access-size enum {ACC_WORD, ACC_BYTE}.
  - Function byte_lane(addr) returning addr[1:0].
- Storage is organised as four byte-lane arrays of WORDS entries each. One sub-module, data_mem_lane, is instantiated four times.
  - data_mem_lane interface: clk, rst, we, index, wdata[7:0], rdata[7:0].
- Top level handles lane write-enable decode and read-mux/zero-extension.

Test Plan:
- Reset then read: rst pulse; read word addresses 0, 4, 1020 -> out_data=0 each.
- Sequential word writes: write word writes at addresses 0..8 with in_data = 32'h11111111*k; then read words 0, 4, 8 -> values last written to each aligned word. Address 5 is aligned to word 1.
- Byte write/read:
  - Write word 32'hAABBCCDD at addr 16.
  - Byte-write 8'h5A at addr 18 -> word read = 32'hAA5ACCDD.
  - Byte read addr 19 -> 32'h000000AA.
- Enables:
  - write_enable=0 with in_data=32'hFFFFFFFF at addr 16 -> contents unchanged.
  - read_enable=0 -> out_data=0.
- Wrap-around: with WORDS=256, word-write 32'hDEADBEEF to addr 1024 -> word read at addr 0 = 32'hDEADBEEF.
- Reset mid-operation: after writes, assert rst asynchronously between edges -> out_data drops to 0 immediately. Write attempted while rst=1 is ignored; reads after deassert are 0.
